// File: rtl/ycr_rst_seq_pkg.sv
// Shared types for the central reset sequencer: FSM states, reset-cause codes
// and small constant helpers.
package ycr_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_WAIT_ACK,
    ST_GAP,
    ST_RUN
  } rst_state_e;

  typedef logic [2:0] rst_cause_t;

  localparam rst_cause_t CAUSE_NONE = 3'd0;
  localparam rst_cause_t CAUSE_POR  = 3'd1;
  localparam rst_cause_t CAUSE_SW   = 3'd2;
  localparam rst_cause_t CAUSE_WDT  = 3'd3;
  localparam rst_cause_t CAUSE_DBG  = 3'd4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Simultaneous requests resolve DBG > WDT > SW.
  function automatic rst_cause_t req_cause(input logic sw, input logic wdt, input logic dbg);
    if (dbg)      return CAUSE_DBG;
    else if (wdt) return CAUSE_WDT;
    else if (sw)  return CAUSE_SW;
    else          return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/ycr_rst_seq_timer.sv
// Loadable, saturating down-counter with a zero flag; used for the hold/gap
// timing and, when enabled, the acknowledge timeout.
module ycr_rst_seq_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ycr_reset_seq_ctrl.sv
// Central reset sequencer: asserts all domain resets, holds, then releases the
// domains in index order gated by their status acknowledge.
// Optional acknowledge/hold timeout: define YCR_RSTSEQ_ACK_TMO_EN.
module ycr_reset_seq_ctrl
  import ycr_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM  = 3,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned ACK_TMO  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_mode,
  input  logic               test_rst_n,
  input  logic               req_sw,
  input  logic               req_wdt,
  input  logic               req_dbg,
  input  logic               clr_cause,
  input  logic [NUM_DOM-1:0] dom_status,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               busy,
  output logic [2:0]         rst_cause,
  output logic               ack_tmo_err
);

  localparam int unsigned CW       = $clog2(max3(HOLD_CYC, GAP_CYC, ACK_TMO) + 1);
  localparam int unsigned IW       = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  // The exit edge of GAP is itself a gap cycle, so the counter starts one short.
  localparam int unsigned GAP_LOAD = (GAP_CYC > 0) ? (GAP_CYC - 1) : 0;

  rst_state_e         state_q, state_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               busy_q, busy_d;
  rst_cause_t         cause_q, cause_d;
  logic               err_q, err_d;

  logic               hg_load, hg_dec, hg_zero;
  logic [CW-1:0]      hg_val;
  logic               tmo_exp;
  logic               req_any;
  logic               is_last;

  assign req_any = req_sw | req_wdt | req_dbg;
  assign is_last = (idx_q == IW'(NUM_DOM - 1));

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    idx_d   = idx_q;
    cause_d = cause_q;
    err_d   = err_q;
    hg_load = 1'b0;
    hg_dec  = 1'b0;
    hg_val  = CW'(HOLD_CYC);

    case (state_q)
      ST_ASSERT: begin
        dom_d   = '0;
        hg_load = 1'b1;
        hg_val  = CW'(HOLD_CYC);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hg_dec = 1'b1;
        if (hg_zero && ((dom_status == '0) || tmo_exp)) begin
          if (dom_status != '0) err_d = 1'b1;
          dom_d    = '0;
          dom_d[0] = 1'b1;
          idx_d    = '0;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (dom_status[idx_q] || tmo_exp) begin
          if (!dom_status[idx_q]) err_d = 1'b1;
          if (is_last) begin
            dom_d   = '1;
            state_d = ST_RUN;
          end else begin
            hg_load = 1'b1;
            hg_val  = CW'(GAP_LOAD);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        hg_dec = 1'b1;
        if (hg_zero) begin
          idx_d        = idx_q + IW'(1);
          dom_d[idx_d] = 1'b1;
          state_d      = ST_WAIT_ACK;
        end
      end
      ST_RUN: begin
        dom_d = '1;
        if (clr_cause) cause_d = CAUSE_NONE;
      end
      default: state_d = ST_ASSERT;
    endcase

    // A request overrides whatever the current state decided, including a clear.
    if (req_any) begin
      state_d = ST_ASSERT;
      dom_d   = '0;
      idx_d   = '0;
      cause_d = req_cause(req_sw, req_wdt, req_dbg);
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      dom_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      err_q   <= err_d;
    end
  end

  ycr_rst_seq_timer #(.W(CW)) u_hold_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (hg_load),
    .load_val (hg_val),
    .dec      (hg_dec),
    .zero     (hg_zero)
  );

`ifdef YCR_RSTSEQ_ACK_TMO_EN
  logic tmo_load, tmo_dec, tmo_zero;

  assign tmo_load = (state_d != state_q) &&
                    ((state_d == ST_HOLD) || (state_d == ST_WAIT_ACK));
  assign tmo_dec  = (state_q == ST_HOLD) || (state_q == ST_WAIT_ACK);
  assign tmo_exp  = tmo_zero && tmo_dec;

  ycr_rst_seq_timer #(.W(CW)) u_ack_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (CW'(ACK_TMO)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  assign dom_rst_n   = test_mode ? {NUM_DOM{test_rst_n}} : dom_q;
  assign busy        = busy_q;
  assign rst_cause   = cause_q;
  assign ack_tmo_err = err_q;

endmodule

// File: doc/ycr_reset_seq_ctrl.md
Name: ycr_reset_seq_ctrl

Overview:
Central reset sequencer. It is the driving end of the per-domain reset buffer/sync cells: it generates the domain reset requests that feed those cells, and consumes the reset status they return. On power-on or on any soft request, it asserts all domain resets together, holds them, then releases the domains one at a time in index order. Before releasing the next domain it waits for the current domain's status acknowledge. It sits at the top of the core's reset tree, upstream of the reset buffer/sync cells.

Parameters:
NUM_DOM, 3, number of reset domains; index 0 is released first.
HOLD_CYC, 16, minimum number of cycles all domain resets stay asserted.
GAP_CYC, 4, idle cycles between an acknowledge and the next domain's release.
ACK_TMO, 255, cycle limit for acknowledge waits (only when the optional feature is compiled in).

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset (power-on)
test_mode  in  1  scan/test mode select
test_rst_n  in  1  test reset, active low
req_sw  in  1  software reset request, single-cycle pulse
req_wdt  in  1  watchdog reset request, single-cycle pulse
req_dbg  in  1  debug reset request, level; treated as a request every cycle it is high
clr_cause  in  1  clears rst_cause; effective in RUN only
dom_status  in  NUM_DOM  per-domain reset status from the buffer cells; 1 = domain out of reset
dom_rst_n  out  NUM_DOM  per-domain reset, active low
busy  out  1  1 whenever the state is not RUN
rst_cause  out  3  cause of the last sequence: 0 none, 1 POR, 2 SW, 3 WDT, 4 DBG
ack_tmo_err  out  1  sticky flag: an acknowledge wait timed out

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- While rst is high:
  - state = ASSERT, dom_rst_n = all 0, busy = 1, rst_cause = 1, ack_tmo_err = 0, domain index = 0.
- All outputs are registered, except for the test bypass below.
- States:
  - ASSERT: all dom_rst_n = 0, hold counter loaded with HOLD_CYC; goes to HOLD on the next edge.
  - HOLD: counter decrements each cycle, saturating at 0. Exits when counter == 0 and dom_status == all 0. On exit, sets dom_rst_n[0] = 1 and goes to WAIT_ACK with index 0.
  - WAIT_ACK: waits for dom_status[index] == 1.
    - On ack with index == NUM_DOM-1: go to RUN.
    - Otherwise: load GAP_CYC and go to GAP.
  - GAP: counter decrements. When it reaches 0: index += 1, dom_rst_n[index] = 1, go to WAIT_ACK.
  - RUN: busy = 0; dom_rst_n = all 1.
- Already-released domains stay released until the next ASSERT.
- Requests:
  - Accepted in every state, including mid-release.
  - An accepted request forces ASSERT on the next edge: all dom_rst_n drop together, the hold count restarts, index = 0.
  - Simultaneous requests set the cause by priority: DBG > WDT > SW.
  - rst_cause updates on every accepted request.
  - A request in the same cycle as clr_cause wins over the clear.
- Status checks:
  - A dom_status bit that goes 0 in RUN is ignored.
  - A dom_status bit already at 1 in WAIT_ACK is an immediate ack; the next edge exits WAIT_ACK.
- Latency with statuses already 0: dom_rst_n[0] rises on edge HOLD_CYC+2 after rst falls.
- Counter width: $clog2(max(HOLD_CYC, GAP_CYC, ACK_TMO)+1).
- Test bypass: when test_mode = 1, every dom_rst_n = test_rst_n combinationally. The FSM keeps running.

Optional Feature:
YCR_RSTSEQ_ACK_TMO_EN
- Defined:
  - A timeout counter loads ACK_TMO on entry to WAIT_ACK and to HOLD.
  - Expiry in WAIT_ACK sets ack_tmo_err and proceeds as if acked.
  - Expiry in HOLD (status still not all 0) sets ack_tmo_err and exits HOLD.
  - ack_tmo_err clears only on rst.
- Undefined: waits are unbounded; ack_tmo_err is tied to 0; no timeout counter is present.

Decomposition:
- Package ycr_rst_seq_pkg holds:
  - state enum typedef (ASSERT, HOLD, WAIT_ACK, GAP, RUN);
  - cause-code typedef and localparams (NONE, POR, SW, WDT, DBG).
- Sub-module ycr_rst_seq_timer: loadable down-counter with a zero flag.
  - One instance serves hold/gap.
  - A second instance serves the ack timeout, present only under the macro.

Test Plan:
1. Defaults, statuses echo dom_rst_n after 2 cycles, rst deasserted at cycle 0 -> dom_rst_n[0] rises at edge 18; dom_rst_n[1] rises 2+GAP_CYC+1 cycles later; busy falls after dom_status[2] = 1; rst_cause = 1.
2. req_sw pulse while in WAIT_ACK for index 1 -> next edge dom_rst_n = 3'b000, busy = 1, rst_cause = 2; full sequence replays from index 0.
3. req_sw, req_wdt and req_dbg in the same cycle -> rst_cause = 4. Then clr_cause in RUN -> rst_cause = 0. clr_cause with req_wdt in the same cycle -> rst_cause = 3.
4. With macro, ACK_TMO = 8, dom_status[1] stuck 0 -> ack_tmo_err = 1 after 8 cycles in WAIT_ACK; sequence continues to RUN. Without macro: FSM stays in WAIT_ACK indefinitely; ack_tmo_err = 0.
5. test_mode = 1, test_rst_n toggled 0/1 mid-HOLD -> dom_rst_n follows test_rst_n in the same cycle. After test_mode = 0, outputs return to FSM values.
6. rst asserted during GAP -> next edge: ASSERT state, dom_rst_n = 0, ack_tmo_err = 0, rst_cause = 1.
